sram_fifo_ctrl: RTL and testbench
=================================

# sram_fifo_ctrl

Single-clock FIFO controller for the AXI4Lite-to-APB4 bridge. It drives both ports of the external dual-port SRAM (write port fed from an upstream valid/ready producer, read port prefetched into a 2-entry output buffer) and presents first-word-fall-through valid/ready data to the downstream stage. It owns the pointers, occupancy, full/empty status and read-latency compensation; the SRAM itself remains a separate instance with 1-cycle registered read.

## Interface
- AW, 4: SRAM address width; SRAM depth = 2^AW; total capacity = 2^AW + 2.
- DW, 32: data width.
- aclk  in  1  clock; both SRAM clocks are tied to it externally.
- aresetn  in  1  asynchronous active-low reset.
- in_valid / in_ready / in_data  in/out/in  1/1/DW  upstream push handshake.
- out_valid / out_ready / out_data  out/in/out  1/1/DW  downstream pop handshake.
- mem_waddr / mem_wdata / mem_wen  out  AW/DW/1  SRAM write port.
- mem_raddr / mem_ren  out  AW/1  SRAM read port.
- mem_rdata  in  DW  SRAM read data, valid the cycle after mem_ren.
- count  out  AW+2  total entries held (SRAM + in-flight read + buffer).
- full / empty  out  1/1  full = !in_ready; empty = (count == 0).
- hwm_clr  in  1  clear high-water mark.
- hwm  out  AW+2  high-water mark of count.

## Operation
- push = in_valid && in_ready; in_ready = (sram_cnt != 2^AW), decoded from registers only, no path from out_ready.
- mem_wen = push, mem_waddr = wptr, mem_wdata = in_data (combinational); wptr increments on push, wraps 2^AW-1 -> 0.
- pop = out_valid && out_ready; out_data = buffer head; buffer is 2-entry FIFO, out_valid = (buf_cnt != 0).
- mem_ren = (sram_cnt != 0) && (buf_cnt + rd_pend - pop < 2); mem_raddr = rptr; rptr increments on mem_ren with wrap.
- rd_pend <= mem_ren; when rd_pend = 1, mem_rdata is written into buffer tail that cycle.
- sram_cnt (AW+1 bits) += push, -= mem_ren; buf_cnt (2 bits) += rd_pend, -= pop; count = sram_cnt + rd_pend + buf_cnt.
- Simultaneous push and mem_ren always legal; mem_ren requires sram_cnt != 0, so read never targets the slot being written the same cycle.
- Simultaneous rd_pend write and pop on full buffer: pop head, write tail, buf_cnt unchanged.
- Ordering strictly FIFO; no data dropped; push while !in_ready has no effect.
- Reset (any time): wptr, rptr, sram_cnt, rd_pend, buf_cnt, hwm cleared; any in-flight SRAM read discarded; SRAM contents not cleared.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, mem_wen 0, mem_ren 0, mem_waddr 0, mem_raddr 0, count 0, full 0, empty 1, hwm 0.
- Latency: word pushed at edge E0 into empty FIFO -> mem_ren during cycle after E0 -> out_valid = 1 after E2.
- Throughput: 1 push and 1 pop per cycle sustained with in_valid = out_ready = 1.
- in_ready deasserts the cycle after the 2^AW-th word lands in SRAM with no concurrent read; reasserts the cycle after the next mem_ren.
- count, full, empty, hwm are registered or decoded from registers; update the cycle after the causing edge.

## Configuration
- SRAM_FIFO_HWM_EN defined: hwm <= max(hwm, next count) each cycle; hwm_clr loads hwm with next count (clear wins over update).
- Not defined: hwm tied to 0, hwm_clr ignored, no hwm register synthesised.

## Test plan
- Reset: hold aresetn = 0 with random inputs -> in_ready 1, out_valid 0, count 0, empty 1, mem_wen 0, mem_ren 0.
- Single word (AW = 2): push 0x11 at E0 with out_ready = 1 -> mem_ren at cycle after E0, out_valid = 1 with out_data 0x11 after E2, popped, count returns to 0.
- Fill (AW = 2): out_ready = 0, push 0xA0..0xA7 continuously -> 6 accepted (0xA0..0xA5), full = 1, count = 6; then out_ready = 1 -> pops 0xA0..0xA5 in order, empty = 1.
- Streaming: in_valid = out_ready = 1, 20 words 0x00..0x13 -> one pop per cycle after initial 2-cycle latency, order preserved across 5 pointer wraps.
- Reset mid-operation: count = 4 with read in flight, pulse aresetn -> count 0, out_valid 0; subsequent push 0x55 pops as 0x55, no stale data.
- HWM (SRAM_FIFO_HWM_EN defined): reach count 5, drain to 0 -> hwm = 5; pulse hwm_clr at count 2 -> hwm = 2; without macro -> hwm = 0 throughout.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
// Purpose  : FIFO controller around an external 1-cycle-read dual-port SRAM, FWFT output.
// Latency  : push at edge E0 into an empty FIFO is visible on out_valid after E2.
// Backpres.: in_ready drops only when the SRAM proper is full; out_ready never reaches in_ready.
//
// Ports
//   aclk, aresetn                     clock, asynchronous active-low reset
//   in_valid/in_ready/in_data         upstream push handshake
//   out_valid/out_ready/out_data      downstream pop handshake (first-word-fall-through)
//   mem_waddr/mem_wdata/mem_wen       SRAM write port
//   mem_raddr/mem_ren/mem_rdata       SRAM read port, rdata valid the cycle after ren
//   count, full, empty                occupancy (SRAM + read in flight + output buffer)
//   hwm_clr, hwm                      high-water mark of count
//
// Build option: define SRAM_FIFO_HWM_EN to include the high-water-mark register;
// otherwise hwm reads as 0 and hwm_clr is ignored.

module sram_fifo_ctrl #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wen,
    output logic [AW-1:0] mem_raddr,
    output logic          mem_ren,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW+1:0] count,
    output logic          full,
    output logic          empty,
    input  logic          hwm_clr,
    output logic [AW+1:0] hwm
);

    localparam int            CW    = AW + 1;
    localparam int            TW    = AW + 2;
    localparam logic [AW:0]   DEPTH = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   sram_cnt;
    logic          rd_pend;
    logic [1:0]    buf_cnt;
    logic          buf_head;
    logic [DW-1:0] buf_q [2];

    logic          push;
    logic          pop;
    logic [2:0]    buf_after;
    logic          wr_slot;
    logic [AW:0]   sram_cnt_nxt;
    logic [1:0]    buf_cnt_nxt;

    // Ready depends on registered SRAM occupancy only.
    assign in_ready  = (sram_cnt != DEPTH);
    assign push      = in_valid && in_ready;
    assign out_valid = (buf_cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = buf_q[buf_head];

    // A push during reset must not reach the SRAM, since in_ready is 1 while reset is held.
    assign mem_wen   = push && aresetn;
    assign mem_waddr = wptr;
    assign mem_wdata = in_data;

    // Issue a read only if the buffer still has room once the in-flight word
    // lands and this cycle's pop leaves. Requiring sram_cnt != 0 guarantees
    // the read never targets the slot being written in the same cycle.
    assign buf_after = 3'(buf_cnt) + 3'(rd_pend) - 3'(pop);
    assign mem_ren   = (sram_cnt != '0) && (buf_after < 3'd2);
    assign mem_raddr = rptr;

    // Tail slot of the 2-entry buffer; when full and popping, the tail is the
    // slot being vacated by the head.
    assign wr_slot = buf_head ^ buf_cnt[0];

    assign sram_cnt_nxt = sram_cnt + CW'(push) - CW'(mem_ren);
    assign buf_cnt_nxt  = buf_cnt + 2'(rd_pend) - 2'(pop);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr     <= '0;
            rptr     <= '0;
            sram_cnt <= '0;
            rd_pend  <= 1'b0;
            buf_cnt  <= 2'd0;
            buf_head <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (mem_ren) begin
                rptr <= rptr + AW'(1);
            end
            sram_cnt <= sram_cnt_nxt;
            rd_pend  <= mem_ren;
            buf_cnt  <= buf_cnt_nxt;
            if (pop) begin
                buf_head <= ~buf_head;
            end
            if (rd_pend) begin
                buf_q[wr_slot] <= mem_rdata;
            end
        end
    end

    assign count = TW'(sram_cnt) + TW'(rd_pend) + TW'(buf_cnt);
    assign full  = !in_ready;
    assign empty = (count == '0);

`ifdef SRAM_FIFO_HWM_EN
    logic [AW+1:0] count_nxt;
    logic [AW+1:0] hwm_q;

    // Occupancy after this edge: rd_pend will equal this cycle's mem_ren.
    assign count_nxt = TW'(sram_cnt_nxt) + TW'(mem_ren) + TW'(buf_cnt_nxt);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hwm_q <= '0;
        end else if (hwm_clr) begin
            hwm_q <= count_nxt;
        end else if (count_nxt > hwm_q) begin
            hwm_q <= count_nxt;
        end
    end

    assign hwm = hwm_q;
`else
    logic unused_hwm_clr;
    assign unused_hwm_clr = hwm_clr;
    assign hwm            = '0;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Purpose  : self-checking bench for sram_fifo_ctrl with a behavioural SRAM and queue model.
// Latency  : checks the 2-cycle first-word latency and 1-word/cycle streaming.
// Backpres.: randomised in_valid/out_ready exercise both stall directions.

module tb_sram_fifo_ctrl;

    localparam int AW    = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;
    localparam int CAP   = DEPTH + 2;

    logic          aclk;
    logic          aresetn;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wen;
    logic [AW-1:0] mem_raddr;
    logic          mem_ren;
    logic [DW-1:0] mem_rdata;
    logic [AW+1:0] count;
    logic          full;
    logic          empty;
    logic          hwm_clr;
    logic [AW+1:0] hwm;

    sram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_wen   (mem_wen),
        .mem_raddr (mem_raddr),
        .mem_ren   (mem_ren),
        .mem_rdata (mem_rdata),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .hwm_clr   (hwm_clr),
        .hwm       (hwm)
    );

    // Behavioural dual-port SRAM with registered read.
    logic [DW-1:0] sram [DEPTH];
    always @(posedge aclk) begin
        if (mem_wen) sram[mem_waddr] <= mem_wdata;
        if (mem_ren) mem_rdata <= sram[mem_raddr];
    end

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int            n_cmp;
    int            n_err;
    logic [DW-1:0] q[$];
    int            hwm_m;
    int            wr_total;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hold reset with random inputs, check reset values, release. Called at a negedge.
    task automatic do_reset();
        aresetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = (i == 2) ? 1'b1 : 1'($urandom);
            in_data   = $urandom;
            out_ready = 1'($urandom);
            hwm_clr   = 1'($urandom);
            @(negedge aclk);
        end
        #1;
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_mem_wen", 64'(mem_wen), 0);
        chk("rst_mem_ren", 64'(mem_ren), 0);
        chk("rst_waddr", 64'(mem_waddr), 0);
        chk("rst_raddr", 64'(mem_raddr), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_full", 64'(full), 0);
        chk("rst_empty", 64'(empty), 1);
        chk("rst_hwm", 64'(hwm), 0);
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        hwm_clr   = 1'b0;
        aresetn   = 1'b1;
        q.delete();
        hwm_m    = 0;
        wr_total = 0;
        @(negedge aclk);
    endtask

    // One model-checked cycle: drive at negedge, account handshakes, check at next negedge.
    task automatic cycle(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic clr);
        logic [DW-1:0] exp_d;
        int            sz;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        hwm_clr   = clr;
        #1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("pop_underflow", 64'(out_valid), 0);
            else begin
                exp_d = q.pop_front();
                chk("pop_data", 64'(out_data), 64'(exp_d));
            end
        end
        if (in_valid && in_ready) begin
            chk("waddr", 64'(mem_waddr), 64'(wr_total % DEPTH));
            chk("wdata", 64'(mem_wdata), 64'(id));
            q.push_back(id);
            wr_total++;
        end
        sz = q.size();
        if (clr) hwm_m = sz;
        else if (sz > hwm_m) hwm_m = sz;
        @(negedge aclk);
        chk("count", 64'(count), 64'(sz));
        chk("empty", 64'(empty), 64'(sz == 0));
        if (sz < DEPTH) chk("ready_below_depth", 64'(in_ready), 1);
        if (sz == CAP) chk("full_at_cap", 64'(full), 1);
`ifdef SRAM_FIFO_HWM_EN
        chk("hwm", 64'(hwm), 64'(hwm_m));
`else
        chk("hwm", 64'(hwm), 0);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] acc[$];
        logic [DW-1:0] got[$];
        int            sent;
        int            first;
        int            last;
        int            n_seen;
        int            piv[3];
        int            por[3];

        n_cmp     = 0;
        n_err     = 0;
        aresetn   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        hwm_clr   = 1'b0;
        @(negedge aclk);

        // ---- single word ----
        do_reset();
        in_valid  = 1'b1;
        in_data   = 32'h11;
        out_ready = 1'b1;
        #1;
        chk("sw_wen", 64'(mem_wen), 1);
        chk("sw_waddr", 64'(mem_waddr), 0);
        chk("sw_wdata", 64'(mem_wdata), 32'h11);
        @(negedge aclk);
        in_valid = 1'b0;
        #1;
        chk("sw_ren_c1", 64'(mem_ren), 1);
        chk("sw_raddr_c1", 64'(mem_raddr), 0);
        chk("sw_ovld_c1", 64'(out_valid), 0);
        chk("sw_count_c1", 64'(count), 1);
        @(negedge aclk);
        #1;
        chk("sw_ren_c2", 64'(mem_ren), 0);
        chk("sw_ovld_c2", 64'(out_valid), 0);
        chk("sw_count_c2", 64'(count), 1);
        @(negedge aclk);
        #1;
        chk("sw_ovld_c3", 64'(out_valid), 1);
        chk("sw_data_c3", 64'(out_data), 32'h11);
        @(negedge aclk);
        #1;
        chk("sw_ovld_c4", 64'(out_valid), 0);
        chk("sw_count_c4", 64'(count), 0);
        chk("sw_empty_c4", 64'(empty), 1);
        @(negedge aclk);

        // ---- fill to capacity, then drain ----
        do_reset();
        out_ready = 1'b0;
        acc.delete();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA0 + DW'(i);
            #1;
            if (in_ready) acc.push_back(in_data);
            @(negedge aclk);
        end
        in_valid = 1'b0;
        #1;
        chk("fill_accepted", 64'(acc.size()), CAP);
        for (int i = 0; i < acc.size(); i++) chk("fill_acc", 64'(acc[i]), 64'(32'hA0 + i));
        chk("fill_full", 64'(full), 1);
        chk("fill_in_ready", 64'(in_ready), 0);
        chk("fill_count", 64'(count), CAP);
        chk("fill_empty", 64'(empty), 0);
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 20 && got.size() < CAP; c++) begin
            if (out_valid) got.push_back(out_data);
            @(negedge aclk);
            #1;
        end
        chk("fill_popped", 64'(got.size()), CAP);
        for (int i = 0; i < got.size(); i++) chk("fill_order", 64'(got[i]), 64'(32'hA0 + i));
        chk("fill_drained_empty", 64'(empty), 1);
        chk("fill_drained_count", 64'(count), 0);
        @(negedge aclk);

        // ---- streaming, 20 words across 5 pointer wraps ----
        do_reset();
        out_ready = 1'b1;
        sent  = 0;
        first = -1;
        last  = -1;
        got.delete();
        for (int c = 0; c < 60 && got.size() < 20; c++) begin
            in_valid = (sent < 20);
            in_data  = DW'(sent);
            #1;
            if (out_valid) begin
                got.push_back(out_data);
                if (first < 0) first = c;
                last = c;
            end
            if (in_valid && in_ready) sent++;
            @(negedge aclk);
        end
        in_valid = 1'b0;
        chk("stream_count", 64'(got.size()), 20);
        for (int i = 0; i < got.size(); i++) chk("stream_order", 64'(got[i]), 64'(i));
        chk("stream_latency", 64'(first), 3);
        chk("stream_rate", 64'(last - first), 19);

        // ---- reset with a read in flight ----
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hC0 + DW'(i);
            @(negedge aclk);
        end
        in_valid  = 1'b1;
        in_data   = 32'hC4;
        out_ready = 1'b1;
        #1;
        chk("mid_ren", 64'(mem_ren), 1);
        chk("mid_pop_data", 64'(out_data), 32'hC0);
        @(negedge aclk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("mid_count", 64'(count), 4);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_count", 64'(count), 0);
        chk("mid_rst_ovld", 64'(out_valid), 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        out_ready = 1'b1;
        n_seen    = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 0);
            in_data  = 32'h55;
            #1;
            if (out_valid) begin
                n_seen++;
                chk("mid_data", 64'(out_data), 32'h55);
            end
            @(negedge aclk);
        end
        in_valid = 1'b0;
        chk("mid_seen", 64'(n_seen), 1);
        chk("mid_final_count", 64'(count), 0);

`ifdef SRAM_FIFO_HWM_EN
        // ---- high-water mark ----
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hD0 + DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("hwm_peak", 64'(hwm), 5);
        for (int i = 0; i < 2; i++) cycle(1'b1, 32'hE0 + DW'(i), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("hwm_after_clr", 64'(hwm), 2);
`endif

        // ---- randomised traffic against the queue model ----
        do_reset();
        piv = '{90, 50, 20};
        por = '{20, 90, 60};
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 250; k++) begin
                cycle(($urandom_range(99) < piv[p]), $urandom,
                      ($urandom_range(99) < por[p]), ($urandom_range(31) == 0));
            end
        end
        for (int k = 0; k < 20; k++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("rand_drained", 64'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
